// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART bridge: frame constants, status bit map,
// transmit FSM encoding and the buffered response payload.
package uart_bridge_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;

    localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'h5A;
    localparam logic [BYTE_W-1:0] VER_DEFAULT = 8'h01;

    localparam int unsigned STAT_ERR_BIT  = 0;
    localparam int unsigned STAT_INTG_BIT = 1;
    localparam int unsigned STAT_WR_BIT   = 2;
    localparam int unsigned STAT_OVR_BIT  = 7;

    typedef enum logic [2:0] {
        TXF_IDLE,
        TXF_SOF,
        TXF_VER,
        TXF_STAT,
        TXF_DATA,
        TXF_CSUM
    } txf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              intg_err;
        logic              is_write;
    } resp_t;

    // Little-endian byte lane select.
    function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/uart_resp_framer_if.sv
// Signal bundle between the TL-UL host adapter / UART transmitter and the framer.
interface uart_resp_framer_if;
    import uart_bridge_pkg::*;

    logic                   req_fire;
    logic                   req_we;
    logic                   valid;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   intg_err;
    logic                   tx_valid;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_ready;
    logic                   busy;

    modport master (
        output req_fire, req_we, valid, rdata, err, intg_err, tx_ready,
        input  tx_valid, tx_data, busy
    );

    modport slave (
        input  req_fire, req_we, valid, rdata, err, intg_err, tx_ready,
        output tx_valid, tx_data, busy
    );

endinterface

// File: rtl/uart_resp_framer.sv
// Turns single-cycle bus responses into byte frames for the UART transmitter,
// with a one-entry pending buffer and a sticky overrun flag.
module uart_resp_framer
    import uart_bridge_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SOF_BYTE = SOF_DEFAULT,
    parameter logic [BYTE_W-1:0] VER_BYTE = VER_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_fire_i,
    input  logic                req_we_i,
    input  logic                valid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                err_i,
    input  logic                intg_err_i,
    output logic                tx_valid_o,
    output logic [BYTE_W-1:0]   tx_data_o,
    input  logic                tx_ready_i,
    output logic                busy_o
);

    txf_state_e          r_state;
    resp_t               r_pend;
    logic                r_pend_full;
    logic                r_ovr;
    logic                r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [BYTE_W-1:0]   r_stat;
    logic [DATA_W-1:0]   r_data;
    logic [BYTE_W-1:0]   r_csum;
    logic                r_is_wr;
    logic                r_tx_valid;
    logic [BYTE_W-1:0]   r_tx_data;

    logic                w_load;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_ld_data;
    logic [BYTE_W-1:0]   w_ld_stat;
    logic [BYTE_W-1:0]   w_ld_dxor;
    logic [BYTE_W-1:0]   w_ld_csum;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_load    = (r_state == TXF_IDLE) && r_pend_full;
    assign w_xfer    = r_tx_valid && tx_ready_i;
    assign w_idx_nxt = r_idx + IDX_W'(1);

    // Frame contents computed from the pending entry at load time.
    always_comb begin
        w_ld_stat = '0;
        w_ld_stat[STAT_ERR_BIT]  = r_pend.err;
        w_ld_stat[STAT_INTG_BIT] = r_pend.intg_err;
        w_ld_stat[STAT_WR_BIT]   = r_pend.is_write;
        w_ld_stat[STAT_OVR_BIT]  = r_ovr;
        w_ld_data = (r_pend.err || r_pend.intg_err) ? DATA_W'(0) : r_pend.rdata;
        w_ld_dxor = get_byte(w_ld_data, 2'd0) ^ get_byte(w_ld_data, 2'd1)
                  ^ get_byte(w_ld_data, 2'd2) ^ get_byte(w_ld_data, 2'd3);
        w_ld_csum = VER_BYTE ^ w_ld_stat ^ (r_pend.is_write ? BYTE_W'(0) : w_ld_dxor);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= TXF_IDLE;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_ovr       <= 1'b0;
            r_tag       <= 1'b0;
            r_idx       <= '0;
            r_stat      <= '0;
            r_data      <= '0;
            r_csum      <= '0;
            r_is_wr     <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            if (req_fire_i) begin
                r_tag <= req_we_i;
            end

            // A response arriving while the buffer drains into the frame is still accepted.
            if (valid_i && (!r_pend_full || w_load)) begin
                r_pend.rdata    <= rdata_i;
                r_pend.err      <= err_i;
                r_pend.intg_err <= intg_err_i;
                r_pend.is_write <= r_tag;
                r_pend_full     <= 1'b1;
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end

            if (w_load) begin
                r_ovr <= 1'b0;
            end else if (valid_i && r_pend_full) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                TXF_IDLE: begin
                    if (w_load) begin
                        r_stat     <= w_ld_stat;
                        r_data     <= w_ld_data;
                        r_csum     <= w_ld_csum;
                        r_is_wr    <= r_pend.is_write;
                        r_idx      <= '0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= SOF_BYTE;
                        r_state    <= TXF_SOF;
                    end
                end
                TXF_SOF: begin
                    if (w_xfer) begin
                        r_tx_data <= VER_BYTE;
                        r_state   <= TXF_VER;
                    end
                end
                TXF_VER: begin
                    if (w_xfer) begin
                        r_tx_data <= r_stat;
                        r_state   <= TXF_STAT;
                    end
                end
                TXF_STAT: begin
                    if (w_xfer) begin
                        if (r_is_wr) begin
                            r_tx_data <= r_csum;
                            r_state   <= TXF_CSUM;
                        end else begin
                            r_idx     <= '0;
                            r_tx_data <= get_byte(r_data, 2'd0);
                            r_state   <= TXF_DATA;
                        end
                    end
                end
                TXF_DATA: begin
                    if (w_xfer) begin
                        if (r_idx == IDX_W'(3)) begin
                            r_idx     <= '0;
                            r_tx_data <= r_csum;
                            r_state   <= TXF_CSUM;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_tx_data <= get_byte(r_data, w_idx_nxt);
                        end
                    end
                end
                TXF_CSUM: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= '0;
                        r_state    <= TXF_IDLE;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                    r_state    <= TXF_IDLE;
                end
            endcase
        end
    end

    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign busy_o     = r_tx_valid || r_pend_full;

endmodule

// File: tb/tb_uart_resp_framer.sv
// Self-checking bench for uart_resp_framer: directed scenarios plus randomized
// traffic compared against a byte-queue frame model.
module tb_uart_resp_framer;
    import uart_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_resp_framer_if bus();

    uart_resp_framer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_fire_i (bus.req_fire),
        .req_we_i   (bus.req_we),
        .valid_i    (bus.valid),
        .rdata_i    (bus.rdata),
        .err_i      (bus.err),
        .intg_err_i (bus.intg_err),
        .tx_valid_o (bus.tx_valid),
        .tx_data_o  (bus.tx_data),
        .tx_ready_i (bus.tx_ready),
        .busy_o     (bus.busy)
    );

    int checks = 0;
    int errors = 0;
    int stab_err = 0;
    int rx_base = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    logic model_tag = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    logic [7:0] prev_data = 8'h00;
    logic       prev_stall = 1'b0;

    // Byte collector and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data))
                stab_err <= stab_err + 1;
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1)
                rx_q.push_back(bus.tx_data);
            prev_stall <= (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
            prev_data  <= bus.tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
    endtask

    task automatic push_frame(input logic [31:0] rd, input logic err, input logic intg,
                              input logic wr, input logic ovr);
        logic [7:0] body[$];
        logic [7:0] cs;
        body.push_back(8'h01);
        body.push_back({ovr, 4'b0000, wr, intg, err});
        if (!wr)
            for (int i = 0; i < 4; i++)
                body.push_back((err || intg) ? 8'h00 : 8'((rd >> (8 * i)) & 32'hFF));
        cs = 8'h00;
        foreach (body[i]) cs = cs ^ body[i];
        exp_q.push_back(8'h5A);
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(cs);
    endtask

    task automatic do_req(input logic we);
        bus.req_fire = 1'b1;
        bus.req_we   = we;
        tick();
        bus.req_fire = 1'b0;
        bus.req_we   = 1'b0;
        model_tag    = we;
    endtask

    task automatic do_resp(input logic [31:0] rd, input logic err, input logic intg);
        bus.valid    = 1'b1;
        bus.rdata    = rd;
        bus.err      = err;
        bus.intg_err = intg;
        tick();
        bus.valid    = 1'b0;
        bus.rdata    = 32'h0;
        bus.err      = 1'b0;
        bus.intg_err = 1'b0;
    endtask

    task automatic send(input logic we, input logic [31:0] rd, input logic err, input logic intg);
        do_req(we);
        do_resp(rd, err, intg);
        push_frame(rd, err, intg, model_tag, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int got;
        while (((rx_q.size() - rx_base) < exp_q.size() || bus.busy === 1'b1) && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
        got = rx_q.size() - rx_base;
        chk({tag, "_len"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_fire = 1'b0;
        bus.req_we   = 1'b0;
        bus.valid    = 1'b0;
        bus.rdata    = 32'h0;
        bus.err      = 1'b0;
        bus.intg_err = 1'b0;
        bus.tx_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'h00);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Known read frame, with SOF latency measured from the response strobe.
        ready_mode = 0;
        do_req(1'b0);
        bus.valid = 1'b1;
        bus.rdata = 32'h11223344;
        tick();
        bus.valid = 1'b0;
        bus.rdata = 32'h0;
        chk("lat_n1_valid", 32'(bus.tx_valid), 32'd0);
        chk("lat_n1_busy",  32'(bus.busy),     32'd1);
        tick();
        chk("lat_n2_valid", 32'(bus.tx_valid), 32'd1);
        chk("lat_n2_sof",   32'(bus.tx_data),  32'h5A);
        push_frame(32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("read_known");
        chk("read_known_csum", 32'(rx_q[rx_base - 1]), 32'h45);

        send(1'b1, $urandom, 1'b0, 1'b0);
        drain("write_known");
        chk("write_known_stat", 32'(rx_q[rx_base - 2]), 32'h04);
        chk("write_known_csum", 32'(rx_q[rx_base - 1]), 32'h05);

        send(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        drain("read_err");
        send(1'b0, $urandom, 1'b0, 1'b1);
        drain("read_intg");

        // Stalled transmitter: third response overruns.
        ready_mode = 2;
        tick();
        do_req(1'b0);
        do_resp(32'hA1A2A3A4, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin tick(); chk("ovr_busy_a", 32'(bus.busy), 32'd1); end
        do_resp(32'hB1B2B3B4, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin tick(); chk("ovr_busy_b", 32'(bus.busy), 32'd1); end
        do_resp(32'hC1C2C3C4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin tick(); chk("ovr_busy_c", 32'(bus.busy), 32'd1); end
        chk("ovr_held_sof", 32'(bus.tx_data), 32'h5A);
        push_frame(32'hA1A2A3A4, 1'b0, 1'b0, 1'b0, 1'b0);
        push_frame(32'hB1B2B3B4, 1'b0, 1'b0, 1'b0, 1'b1);
        ready_mode = 1;
        drain("overrun");

        // Randomized traffic under random backpressure.
        for (int k = 0; k < 16; k++) begin
            send(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            drain($sformatf("rand%0d", k));
        end
        chk("hold_stable", 32'(stab_err), 32'd0);

        // Reset in the middle of the data bytes.
        ready_mode = 0;
        send(1'b0, $urandom, 1'b0, 1'b0);
        begin
            int n = 0;
            while ((rx_q.size() - rx_base) < 4 && n < 50) begin tick(); n++; end
            chk("mid_reach_data", 32'(n < 50), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_rst_data",  32'(bus.tx_data),  32'h00);
        chk("mid_rst_busy",  32'(bus.busy),     32'd0);
        rst_n = 1'b1;
        model_tag = 1'b0;
        tick();
        rx_base = rx_q.size();
        exp_q.delete();
        send(1'b0, $urandom, 1'b0, 1'b0);
        drain("post_rst");
        chk("post_rst_sof", 32'(rx_q[rx_base - 8]), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
